match_req_arbiter: RTL and testbench
====================================

// Module: match_req_arbiter
// PURPOSE
//  Shares one match PE among JOB_PE_NUM job PEs. Round-robin arbitration merges their
//  match requests into a registered output stream, tagged with the job PE id.
//  Responses are routed back by id. A per-PE outstanding counter bounds in-flight requests.
//  Sits between the job_pe match req/resp ports and the match PE.
// PARAMETERS
//  NUM_PE        `JOB_PE_NUM  number of requesting job PEs (power of two, >=2)
//  MAX_OUTST     4            max in-flight requests per job PE (1..15)
// PORTS
//  clk                  in   1                        clock
//  rst                  in   1                        reset: asynchronous, active-high
//  i_req_valid          in   NUM_PE                   per-PE request valid
//  i_req_head_addr      in   NUM_PE*`ADDR_WIDTH       per-PE head address
//  i_req_history_addr   in   NUM_PE*`ADDR_WIDTH       per-PE history address
//  i_req_slot_id        in   NUM_PE*`ROW_SIZE_LOG2    per-PE slot id
//  o_req_ready          out  NUM_PE                   per-PE request ready
//  o_mreq_valid         out  1                        merged request valid
//  o_mreq_head_addr     out  `ADDR_WIDTH              merged head address
//  o_mreq_history_addr  out  `ADDR_WIDTH              merged history address
//  o_mreq_job_pe_id     out  `JOB_PE_NUM_LOG2         source PE of request
//  o_mreq_slot_id       out  `ROW_SIZE_LOG2           slot id
//  i_mreq_ready         in   1                        match PE accepts
//  i_mresp_valid        in   1                        match PE response valid
//  i_mresp_job_pe_id    in   `JOB_PE_NUM_LOG2         destination PE
//  i_mresp_slot_id      in   `ROW_SIZE_LOG2           slot id
//  i_mresp_len          in   `MAX_MATCH_LEN_LOG2+1    match length
//  o_mresp_ready        out  1                        = i_resp_ready[i_mresp_job_pe_id]
//  o_resp_valid         out  NUM_PE                   one-hot routed response valid
//  o_resp_slot_id       out  `ROW_SIZE_LOG2           broadcast slot id
//  o_resp_len           out  `MAX_MATCH_LEN_LOG2+1    broadcast length
//  i_resp_ready         in   NUM_PE                   per-PE response ready
//  o_err_underflow      out  1                        sticky: response to PE with zero outstanding
// BEHAVIOUR
//  - Reset: o_mreq_valid=0, skid buffer empty, RR pointer=NUM_PE-1, all counters 0,
//    o_err_underflow=0. o_req_ready/o_resp_valid are combinational and follow from this state.
//  - Eligible PE p: i_req_valid[p] && cnt[p]<MAX_OUTST.
//    Grant: first eligible index after the pointer, in order ptr+1..ptr+NUM_PE, mod NUM_PE.
//  - o_req_ready[p]=1 only for the granted PE, and only when the 2-entry skid buffer has space.
//    Output fields come from the skid head register. Accept-to-output latency is 1 cycle.
//    Sustained throughput is 1/cycle.
//  - On accept: pointer<=granted idx; cnt[p]++. On resp handshake to PE q: cnt[q]--.
//    Same-cycle inc and dec on the same PE: net 0.
//  - Response path is combinational. o_resp_valid[q]=i_mresp_valid when q==id, otherwise 0.
//    Data is broadcast. The handshake completes when i_mresp_valid && o_mresp_ready.
//  - Response while cnt[q]==0: still routed; cnt stays 0; o_err_underflow<=1 (sticky until rst).
//  - i_mreq_ready low: skid buffer holds its data; o_mreq_* stay stable while valid.
//    Once full, all o_req_ready=0.
//  - Reset asserted mid-operation: skid contents and counters are discarded immediately.
// STRUCTURE
//  - Shared package/header: JOB_PE_NUM, JOB_PE_NUM_LOG2, ADDR_WIDTH, ROW_SIZE_LOG2,
//    MAX_MATCH_LEN_LOG2. Add a packed request-record width macro
//    MATCH_REQ_W = 2*ADDR_WIDTH+JOB_PE_NUM_LOG2+ROW_SIZE_LOG2.
//  - Sub-module rr_arbiter (NUM_PE): eligibility vec + pointer -> one-hot grant, index.
//    Pointer update lives in the parent.
// TESTING
//  1 Reset: assert rst mid-burst -> o_mreq_valid=0, cnt=0, next grant goes to PE0.
//  2 All 4 PEs valid, i_mreq_ready=1 -> job_pe_id order 0,1,2,3,0..., one request/cycle
//    after 1-cycle latency.
//  3 PE2 issues 4 requests with no responses -> PE2 ready stays 0 while others keep flowing.
//    One response to PE2 -> PE2 granted on the next RR turn.
//  4 i_mreq_ready=0 for 5 cycles with 3 PEs valid -> exactly 2 accepted, outputs stable.
//    On release, accepted items drain in order.
//  5 Response id=1, len=17, i_resp_ready[1]=0 -> o_resp_valid=4'b0010, o_mresp_ready=0.
//    Ready raised -> cnt[1] decrements once.
//  6 Response to PE3 with cnt[3]=0 -> o_err_underflow=1 from the next cycle, held until rst.

Source files
------------

// File: rtl/match_req_arbiter_pkg.sv
// Shared parameters and types for the match request arbiter.
//   JOB_PE_NUM / JOB_PE_NUM_LOG2 : number of job PEs and id width
//   ADDR_WIDTH                   : head/history address width
//   ROW_SIZE_LOG2                : slot id width
//   MAX_MATCH_LEN_LOG2           : match length width is this + 1
//   MATCH_REQ_W                  : width of one packed request record
package match_req_arbiter_pkg;

  localparam int JOB_PE_NUM         = 4;
  localparam int JOB_PE_NUM_LOG2    = 2;
  localparam int ADDR_WIDTH         = 16;
  localparam int ROW_SIZE_LOG2      = 4;
  localparam int MAX_MATCH_LEN_LOG2 = 5;
  localparam int MATCH_REQ_W        = 2*ADDR_WIDTH + JOB_PE_NUM_LOG2 + ROW_SIZE_LOG2;

  // Outstanding counters must hold values up to 15.
  localparam int CNT_W = 4;

  // One request as it sits in the skid buffer.
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]      headAddr;
    logic [ADDR_WIDTH-1:0]      historyAddr;
    logic [JOB_PE_NUM_LOG2-1:0] jobPeId;
    logic [ROW_SIZE_LOG2-1:0]   slotId;
  } match_req_t;

endpackage

// File: rtl/match_req_arbiter_rr_arbiter.sv
// Purely combinational round-robin arbiter.
//   i_eligible  : per-requester eligibility
//   i_ptr       : index of the last granted requester
//   o_grant     : one-hot grant
//   o_grant_idx : binary index of the grant (valid when o_grant_any)
//   o_grant_any : at least one requester is eligible
// The pointer register is owned by the parent.
module rr_arbiter
  import match_req_arbiter_pkg::*;
#(
  parameter int NUM_PE = JOB_PE_NUM,
  parameter int IDX_W  = $clog2(NUM_PE)
) (
  input  logic [NUM_PE-1:0] i_eligible,
  input  logic [IDX_W-1:0]  i_ptr,
  output logic [NUM_PE-1:0] o_grant,
  output logic [IDX_W-1:0]  o_grant_idx,
  output logic              o_grant_any
);

  logic [IDX_W-1:0] w_candidate;

  // Search ptr+1 .. ptr+NUM_PE; NUM_PE is a power of two, so the index
  // wraps by truncation and the pointer itself is examined last.
  always_comb begin
    o_grant     = '0;
    o_grant_idx = i_ptr;
    o_grant_any = 1'b0;
    w_candidate = i_ptr;
    for (int i = 1; i <= NUM_PE; i++) begin
      w_candidate = i_ptr + IDX_W'(i);
      if (!o_grant_any && i_eligible[w_candidate]) begin
        o_grant_any = 1'b1;
        o_grant_idx = w_candidate;
      end
    end
    if (o_grant_any) begin
      o_grant[o_grant_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/match_req_arbiter.sv
// Shares one match PE among NUM_PE job PEs.
//   Request side : i_req_* per PE, o_req_ready per PE (only the granted PE,
//                  only while the 2-entry skid buffer has room)
//   Merged side  : o_mreq_* driven from the skid head register, tagged with
//                  the source PE id; i_mreq_ready from the match PE
//   Response side: i_mresp_* routed combinationally to o_resp_valid[id],
//                  slot/len broadcast, o_mresp_ready = i_resp_ready[id]
//   o_err_underflow: sticky flag for a response to a PE with nothing in flight
module match_req_arbiter
  import match_req_arbiter_pkg::*;
#(
  parameter int NUM_PE    = JOB_PE_NUM,
  parameter int MAX_OUTST = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PE-1:0]               i_req_valid,
  input  logic [NUM_PE*ADDR_WIDTH-1:0]    i_req_head_addr,
  input  logic [NUM_PE*ADDR_WIDTH-1:0]    i_req_history_addr,
  input  logic [NUM_PE*ROW_SIZE_LOG2-1:0] i_req_slot_id,
  output logic [NUM_PE-1:0]               o_req_ready,
  output logic                            o_mreq_valid,
  output logic [ADDR_WIDTH-1:0]           o_mreq_head_addr,
  output logic [ADDR_WIDTH-1:0]           o_mreq_history_addr,
  output logic [JOB_PE_NUM_LOG2-1:0]      o_mreq_job_pe_id,
  output logic [ROW_SIZE_LOG2-1:0]        o_mreq_slot_id,
  input  logic                            i_mreq_ready,
  input  logic                            i_mresp_valid,
  input  logic [JOB_PE_NUM_LOG2-1:0]      i_mresp_job_pe_id,
  input  logic [ROW_SIZE_LOG2-1:0]        i_mresp_slot_id,
  input  logic [MAX_MATCH_LEN_LOG2:0]     i_mresp_len,
  output logic                            o_mresp_ready,
  output logic [NUM_PE-1:0]               o_resp_valid,
  output logic [ROW_SIZE_LOG2-1:0]        o_resp_slot_id,
  output logic [MAX_MATCH_LEN_LOG2:0]     o_resp_len,
  input  logic [NUM_PE-1:0]               i_resp_ready,
  output logic                            o_err_underflow
);

  localparam int IDX_W = JOB_PE_NUM_LOG2;

  logic [NUM_PE-1:0]      w_eligible;
  logic [NUM_PE-1:0]      w_grant;
  logic [IDX_W-1:0]       w_grantIdx;
  logic                   w_grantAny;
  logic [IDX_W-1:0]       r_ptr;
  logic                   r_headValid;
  logic                   r_tailValid;
  logic [MATCH_REQ_W-1:0] r_headData;
  logic [MATCH_REQ_W-1:0] r_tailData;
  match_req_t             w_newReq;
  match_req_t             w_headReq;
  logic                   w_space;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_respFire;
  logic [CNT_W-1:0]       r_cnt [NUM_PE];
  logic                   r_errUnderflow;

  // A PE may compete only while it is below its in-flight limit.
  always_comb begin
    w_eligible = '0;
    for (int p = 0; p < NUM_PE; p++) begin
      w_eligible[p] = i_req_valid[p] && (r_cnt[p] < CNT_W'(MAX_OUTST));
    end
  end

  rr_arbiter #(
    .NUM_PE (NUM_PE),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .i_eligible  (w_eligible),
    .i_ptr       (r_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grantIdx),
    .o_grant_any (w_grantAny)
  );

  // The tail entry is only ever filled behind a valid head, so an empty
  // tail means there is room. Ready depends on registered state only.
  assign w_space     = !r_tailValid;
  assign o_req_ready = w_space ? w_grant : '0;
  assign w_push      = w_space && w_grantAny;
  assign w_pop       = r_headValid && i_mreq_ready;

  always_comb begin
    w_newReq.headAddr    = i_req_head_addr[w_grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
    w_newReq.historyAddr = i_req_history_addr[w_grantIdx*ADDR_WIDTH +: ADDR_WIDTH];
    w_newReq.jobPeId     = w_grantIdx;
    w_newReq.slotId      = i_req_slot_id[w_grantIdx*ROW_SIZE_LOG2 +: ROW_SIZE_LOG2];
  end

  // Skid buffer and round-robin pointer. Push with pop can only happen
  // while the tail is empty, so the new entry goes straight to the head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr       <= IDX_W'(NUM_PE - 1);
      r_headValid <= 1'b0;
      r_tailValid <= 1'b0;
      r_headData  <= '0;
      r_tailData  <= '0;
    end else begin
      if (w_push) begin
        r_ptr <= w_grantIdx;
      end
      case ({w_pop, w_push})
        2'b11: r_headData <= w_newReq;
        2'b10: begin
          r_headData  <= r_tailData;
          r_headValid <= r_tailValid;
          r_tailValid <= 1'b0;
        end
        2'b01: begin
          if (!r_headValid) begin
            r_headData  <= w_newReq;
            r_headValid <= 1'b1;
          end else begin
            r_tailData  <= w_newReq;
            r_tailValid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_headReq           = match_req_t'(r_headData);
  assign o_mreq_valid        = r_headValid;
  assign o_mreq_head_addr    = w_headReq.headAddr;
  assign o_mreq_history_addr = w_headReq.historyAddr;
  assign o_mreq_job_pe_id    = w_headReq.jobPeId;
  assign o_mreq_slot_id      = w_headReq.slotId;

  // Response routing: valid goes only to the addressed PE, data is shared.
  assign o_mresp_ready  = i_resp_ready[i_mresp_job_pe_id];
  assign w_respFire     = i_mresp_valid && o_mresp_ready;
  assign o_resp_slot_id = i_mresp_slot_id;
  assign o_resp_len     = i_mresp_len;

  always_comb begin
    o_resp_valid = '0;
    if (i_mresp_valid) begin
      o_resp_valid[i_mresp_job_pe_id] = 1'b1;
    end
  end

  // Outstanding counters. A response to an idle PE saturates at zero and
  // raises the sticky error instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < NUM_PE; p++) begin
        r_cnt[p] <= '0;
      end
      r_errUnderflow <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PE; p++) begin
        logic inc;
        logic dec;
        inc = w_push && (w_grantIdx == IDX_W'(p));
        dec = w_respFire && (i_mresp_job_pe_id == IDX_W'(p)) && (r_cnt[p] != '0);
        if (inc && !dec) begin
          r_cnt[p] <= r_cnt[p] + 1'b1;
        end else if (dec && !inc) begin
          r_cnt[p] <= r_cnt[p] - 1'b1;
        end
      end
      if (w_respFire && (r_cnt[i_mresp_job_pe_id] == '0)) begin
        r_errUnderflow <= 1'b1;
      end
    end
  end

  assign o_err_underflow = r_errUnderflow;

endmodule

// File: tb/tb_match_req_arbiter.sv
// Directed, self-checking bench for match_req_arbiter (4 job PEs).
module tb_match_req_arbiter;
  import match_req_arbiter_pkg::*;

  localparam int NPE = JOB_PE_NUM;
  localparam int LW  = MAX_MATCH_LEN_LOG2 + 1;

  logic                         clk;
  logic                         rst;
  logic [NPE-1:0]               reqValid;
  logic [NPE*ADDR_WIDTH-1:0]    reqHeadAddr;
  logic [NPE*ADDR_WIDTH-1:0]    reqHistoryAddr;
  logic [NPE*ROW_SIZE_LOG2-1:0] reqSlotId;
  logic [NPE-1:0]               reqReady;
  logic                         mreqValid;
  logic [ADDR_WIDTH-1:0]        mreqHeadAddr;
  logic [ADDR_WIDTH-1:0]        mreqHistoryAddr;
  logic [JOB_PE_NUM_LOG2-1:0]   mreqJobPeId;
  logic [ROW_SIZE_LOG2-1:0]     mreqSlotId;
  logic                         mreqReady;
  logic                         mrespValid;
  logic [JOB_PE_NUM_LOG2-1:0]   mrespJobPeId;
  logic [ROW_SIZE_LOG2-1:0]     mrespSlotId;
  logic [LW-1:0]                mrespLen;
  logic                         mrespReady;
  logic [NPE-1:0]               respValid;
  logic [ROW_SIZE_LOG2-1:0]     respSlotId;
  logic [LW-1:0]                respLen;
  logic [NPE-1:0]               respReady;
  logic                         errUnderflow;

  match_req_arbiter #(.NUM_PE(NPE), .MAX_OUTST(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .i_req_valid         (reqValid),
    .i_req_head_addr     (reqHeadAddr),
    .i_req_history_addr  (reqHistoryAddr),
    .i_req_slot_id       (reqSlotId),
    .o_req_ready         (reqReady),
    .o_mreq_valid        (mreqValid),
    .o_mreq_head_addr    (mreqHeadAddr),
    .o_mreq_history_addr (mreqHistoryAddr),
    .o_mreq_job_pe_id    (mreqJobPeId),
    .o_mreq_slot_id      (mreqSlotId),
    .i_mreq_ready        (mreqReady),
    .i_mresp_valid       (mrespValid),
    .i_mresp_job_pe_id   (mrespJobPeId),
    .i_mresp_slot_id     (mrespSlotId),
    .i_mresp_len         (mrespLen),
    .o_mresp_ready       (mrespReady),
    .o_resp_valid        (respValid),
    .o_resp_slot_id      (respSlotId),
    .o_resp_len          (respLen),
    .i_resp_ready        (respReady),
    .o_err_underflow     (errUnderflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic [3:0]    reqValid;
    logic          mrespValid;
    logic [1:0]    id;
    logic [LW-1:0] len;
    logic [3:0]    respReady;
    logic [3:0]    expReqReady;
    logic [3:0]    expRespValid;
    logic          expMrespReady;
  } vec_t;

  vec_t vecs [6];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] rv, input logic mr, input logic mv,
                               input logic [1:0] id, input logic [LW-1:0] len,
                               input logic [3:0] rr);
    reqValid     = rv;
    mreqReady    = mr;
    mrespValid   = mv;
    mrespJobPeId = id;
    mrespLen     = len;
    mrespSlotId  = 4'(id + 8);
    respReady    = rr;
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0, '0, 4'b0000);
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int p = 0; p < NPE; p++) begin
      reqHeadAddr[p*ADDR_WIDTH +: ADDR_WIDTH]       = 16'h1000 + 16'(p);
      reqHistoryAddr[p*ADDR_WIDTH +: ADDR_WIDTH]    = 16'h2000 + 16'(p);
      reqSlotId[p*ROW_SIZE_LOG2 +: ROW_SIZE_LOG2]   = 4'(p + 4);
    end
    applyStimulus(4'b0000, 1'b0, 1'b0, 2'd0, '0, 4'b0000);

    //          reqV     mv    id    len     rr       expReqRdy expRespV expMRdy
    vecs[0] = '{4'b0000, 1'b0, 2'd0, 6'd0,  4'b0101, 4'b0000, 4'b0000, 1'b1};
    vecs[1] = '{4'b1111, 1'b0, 2'd2, 6'd0,  4'b0101, 4'b0001, 4'b0000, 1'b1};
    vecs[2] = '{4'b1010, 1'b1, 2'd1, 6'd17, 4'b0000, 4'b0010, 4'b0010, 1'b0};
    vecs[3] = '{4'b1000, 1'b1, 2'd3, 6'd31, 4'b1000, 4'b1000, 4'b1000, 1'b1};
    vecs[4] = '{4'b0100, 1'b1, 2'd2, 6'd3,  4'b1011, 4'b0100, 4'b0100, 1'b0};
    vecs[5] = '{4'b0110, 1'b0, 2'd0, 6'd8,  4'b0001, 4'b0010, 4'b0000, 1'b1};

    tick();
    tick();

    // Reset held: state is frozen, combinational paths are exercised.
    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].reqValid, 1'b0, vecs[v].mrespValid, vecs[v].id, vecs[v].len, vecs[v].respReady);
      checkOutput($sformatf("vec%0d reqReady", v), 32'(reqReady), 32'(vecs[v].expReqReady));
      checkOutput($sformatf("vec%0d respValid", v), 32'(respValid), 32'(vecs[v].expRespValid));
      checkOutput($sformatf("vec%0d mrespReady", v), 32'(mrespReady), 32'(vecs[v].expMrespReady));
      checkOutput($sformatf("vec%0d respLen", v), 32'(respLen), 32'(vecs[v].len));
      checkOutput($sformatf("vec%0d respSlot", v), 32'(respSlotId), 32'(vecs[v].id) + 8);
      checkOutput($sformatf("vec%0d mreqValid", v), 32'(mreqValid), 32'd0);
      checkOutput($sformatf("vec%0d err", v), 32'(errUnderflow), 32'd0);
      tick();
    end

    // All four PEs requesting, match PE always ready.
    applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0, '0, 4'b0000);
    rst = 1'b0;
    applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("rr start reqReady", 32'(reqReady), 32'h1);
    checkOutput("rr start mreqValid", 32'(mreqValid), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      checkOutput($sformatf("rr%0d mreqValid", k), 32'(mreqValid), 32'd1);
      checkOutput($sformatf("rr%0d id", k), 32'(mreqJobPeId), 32'((k - 1) % 4));
      checkOutput($sformatf("rr%0d head", k), 32'(mreqHeadAddr), 32'h1000 + 32'((k - 1) % 4));
      checkOutput($sformatf("rr%0d hist", k), 32'(mreqHistoryAddr), 32'h2000 + 32'((k - 1) % 4));
      checkOutput($sformatf("rr%0d slot", k), 32'(mreqSlotId), 32'((k - 1) % 4 + 4));
      checkOutput($sformatf("rr%0d reqReady", k), 32'(reqReady), 32'(1 << (k % 4)));
    end

    // Reset in the middle of the burst takes effect without a clock edge.
    rst = 1'b1;
    #1;
    checkOutput("midrst mreqValid", 32'(mreqValid), 32'd0);
    checkOutput("midrst reqReady", 32'(reqReady), 32'h1);
    tick();
    rst = 1'b0;
    #1;
    checkOutput("postrst reqReady", 32'(reqReady), 32'h1);
    tick();
    checkOutput("postrst id", 32'(mreqJobPeId), 32'd0);
    checkOutput("postrst mreqValid", 32'(mreqValid), 32'd1);

    // PE2 reaches its in-flight limit, others keep flowing, one response
    // lets PE2 back in on its next turn.
    doReset();
    applyStimulus(4'b0100, 1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("lim start reqReady", 32'(reqReady), 32'h4);
    for (int k = 1; k <= 4; k++) begin
      tick();
      checkOutput($sformatf("lim%0d id", k), 32'(mreqJobPeId), 32'd2);
      checkOutput($sformatf("lim%0d reqReady", k), 32'(reqReady), (k < 4) ? 32'h4 : 32'h0);
    end
    applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("lim others a", 32'(reqReady), 32'h8);
    tick();
    checkOutput("lim others b", 32'(reqReady), 32'h1);
    tick();
    checkOutput("lim others c", 32'(reqReady), 32'h2);
    tick();
    checkOutput("lim skip pe2", 32'(reqReady), 32'h8);
    applyStimulus(4'b1111, 1'b1, 1'b1, 2'd2, 6'd5, 4'b0100);
    checkOutput("lim resp valid", 32'(respValid), 32'h4);
    checkOutput("lim resp ready", 32'(mrespReady), 32'd1);
    tick();
    applyStimulus(4'b1111, 1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("lim turn 0", 32'(reqReady), 32'h1);
    tick();
    checkOutput("lim turn 1", 32'(reqReady), 32'h2);
    tick();
    checkOutput("lim turn pe2", 32'(reqReady), 32'h4);
    tick();
    checkOutput("lim pe2 out", 32'(mreqJobPeId), 32'd2);

    // Back-pressure: exactly two requests are taken, outputs hold, then drain.
    doReset();
    applyStimulus(4'b0111, 1'b0, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("bp reqReady 0", 32'(reqReady), 32'h1);
    tick();
    checkOutput("bp reqReady 1", 32'(reqReady), 32'h2);
    checkOutput("bp id 1", 32'(mreqJobPeId), 32'd0);
    tick();
    checkOutput("bp reqReady 2", 32'(reqReady), 32'h0);
    for (int k = 3; k <= 5; k++) begin
      tick();
      checkOutput($sformatf("bp hold%0d valid", k), 32'(mreqValid), 32'd1);
      checkOutput($sformatf("bp hold%0d id", k), 32'(mreqJobPeId), 32'd0);
      checkOutput($sformatf("bp hold%0d head", k), 32'(mreqHeadAddr), 32'h1000);
      checkOutput($sformatf("bp hold%0d reqReady", k), 32'(reqReady), 32'h0);
    end
    applyStimulus(4'b0111, 1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("bp release reqReady", 32'(reqReady), 32'h0);
    tick();
    checkOutput("bp drain id1", 32'(mreqJobPeId), 32'd1);
    checkOutput("bp drain reqReady", 32'(reqReady), 32'h4);
    tick();
    checkOutput("bp drain id2", 32'(mreqJobPeId), 32'd2);

    // Response to PE1 stalled by its ready, then completed exactly once.
    doReset();
    applyStimulus(4'b0010, 1'b1, 1'b0, 2'd0, '0, 4'b0000);
    tick();
    checkOutput("resp req id", 32'(mreqJobPeId), 32'd1);
    applyStimulus(4'b0000, 1'b1, 1'b1, 2'd1, 6'd17, 4'b0000);
    checkOutput("resp stall valid", 32'(respValid), 32'h2);
    checkOutput("resp stall ready", 32'(mrespReady), 32'd0);
    checkOutput("resp stall len", 32'(respLen), 32'd17);
    tick();
    tick();
    checkOutput("resp stall err", 32'(errUnderflow), 32'd0);
    applyStimulus(4'b0000, 1'b1, 1'b1, 2'd1, 6'd17, 4'b0010);
    checkOutput("resp go ready", 32'(mrespReady), 32'd1);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("resp done err", 32'(errUnderflow), 32'd0);
    applyStimulus(4'b0000, 1'b1, 1'b1, 2'd1, 6'd17, 4'b0010);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("resp extra err", 32'(errUnderflow), 32'd1);

    // Response to idle PE3: sticky error until reset.
    doReset();
    checkOutput("uf reset err", 32'(errUnderflow), 32'd0);
    applyStimulus(4'b0000, 1'b1, 1'b1, 2'd3, 6'd9, 4'b1000);
    checkOutput("uf resp valid", 32'(respValid), 32'h8);
    checkOutput("uf before edge", 32'(errUnderflow), 32'd0);
    tick();
    applyStimulus(4'b0000, 1'b1, 1'b0, 2'd0, '0, 4'b0000);
    checkOutput("uf set", 32'(errUnderflow), 32'd1);
    tick();
    tick();
    tick();
    checkOutput("uf sticky", 32'(errUnderflow), 32'd1);
    doReset();
    checkOutput("uf cleared", 32'(errUnderflow), 32'd0);

    // Same-cycle accept and response on PE0 leaves its count unchanged.
    applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0, '0, 4'b0000);
    tick();
    applyStimulus(4'b0001, 1'b1, 1'b1, 2'd0, 6'd1, 4'b0001);
    checkOutput("net0 reqReady", 32'(reqReady), 32'h1);
    tick();
    applyStimulus(4'b0001, 1'b1, 1'b0, 2'd0, '0, 4'b0000);
    for (int k = 1; k <= 3; k++) begin
      tick();
      checkOutput($sformatf("net0 fill%0d", k), 32'(reqReady), (k < 3) ? 32'h1 : 32'h0);
    end
    checkOutput("net0 err", 32'(errUnderflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
